// File: rtl/mem_arbiter_2to1.sv
// Two-master line-request arbiter merging I-cache and D-cache onto one memory port.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on contention instead of D-over-I priority.
module mem_arbiter_2to1 #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              dc_req;
  logic              grant_dc;

  assign dc_req = dc_read | dc_write;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_last: 0 = I-cache served last, 1 = D-cache served last
  logic rr_last_q, rr_last_d;
  assign grant_dc = dc_req & (~ic_read | ~rr_last_q);
`else
  assign grant_dc = dc_req;
`endif

  // Next-state, captured request and steered ready pulses
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_ready    = 1'b0;
    dc_ready    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_last_d   = rr_last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_dc) begin
          state_d     = ST_BUSY_D;
          mem_write_d = dc_write;
          mem_read_d  = ~dc_write;
          mem_addr_d  = dc_addr;
          mem_wdata_d = dc_wdata;
        end else if (ic_read) begin
          state_d     = ST_BUSY_I;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = ic_addr;
          mem_wdata_d = '0;
        end
      end
      ST_BUSY_I: begin
        if (mem_ready) begin
          ic_ready    = 1'b1;
          state_d     = ST_IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          rr_last_d   = 1'b0;
`endif
        end
      end
      ST_BUSY_D: begin
        if (mem_ready) begin
          dc_ready    = 1'b1;
          state_d     = ST_IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          rr_last_d   = 1'b1;
`endif
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= ST_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) rr_last_q <= 1'b0;
    else            rr_last_q <= rr_last_d;
  end
`endif

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // Read data fans out to both caches; only the ready pulse is steered
  assign ic_rdata  = mem_rdata;
  assign dc_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Self-checking bench for mem_arbiter_2to1: expected transfers queued at request time,
// checked by a memory responder as the arbiter issues them.
module tb_mem_arbiter_2to1;

  typedef struct packed {
    logic         is_dc;
    logic         is_wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } xfer_t;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         ic_read, dc_read, dc_write;
  logic [27:0]  ic_addr, dc_addr;
  logic [127:0] dc_wdata, mem_rdata;
  logic         mem_ready;
  logic [127:0] ic_rdata, dc_rdata, mem_wdata;
  logic         ic_ready, dc_ready, mem_read, mem_write;
  logic [27:0]  mem_addr;

  xfer_t sb[$];
  int    total = 0;
  int    bad   = 0;

  mem_arbiter_2to1 dut (
    .clk(clk), .proc_reset(proc_reset),
    .ic_read(ic_read), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
    .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_ready(dc_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    proc_reset = 1'b1;
    ic_read = 1'b0; dc_read = 1'b0; dc_write = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    proc_reset = 1'b0;
  endtask

  // Memory responder: waits for a strobe, checks it against the queue head, answers after dly cycles
  task automatic serve(input int dly, input logic [127:0] rd, input bit drop);
    xfer_t e;
    int n;
    n = 0;
    while (!(mem_read || mem_write) && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL serve_timeout: no memory strobe within 50 cycles");
      return;
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: unexpected transfer addr=%h", mem_addr);
      return;
    end
    e = sb.pop_front();
    total++;
    if ({mem_write, mem_read, mem_addr} !== {e.is_wr, ~e.is_wr, e.addr}) begin
      bad++;
      $display("FAIL xfer_req: got wr=%b rd=%b addr=%h want wr=%b rd=%b addr=%h",
               mem_write, mem_read, mem_addr, e.is_wr, ~e.is_wr, e.addr);
    end
    if (e.is_wr) begin
      total++;
      if (mem_wdata !== e.wdata) begin
        bad++;
        $display("FAIL xfer_wdata: got %h want %h", mem_wdata, e.wdata);
      end
    end
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      total++;
      if (mem_addr !== e.addr || (mem_read | mem_write) !== 1'b1 || ic_ready !== 1'b0 || dc_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold: addr=%h strobe=%b ic_ready=%b dc_ready=%b want addr=%h strobe=1 readies=0",
                 mem_addr, mem_read | mem_write, ic_ready, dc_ready, e.addr);
      end
    end
    mem_rdata = rd;
    mem_ready = 1'b1;
    #1;
    total++;
    if ({ic_ready, dc_ready} !== {~e.is_dc, e.is_dc}) begin
      bad++;
      $display("FAIL ready_steer: got ic=%b dc=%b want ic=%b dc=%b", ic_ready, dc_ready, ~e.is_dc, e.is_dc);
    end
    total++;
    if (ic_rdata !== rd || dc_rdata !== rd) begin
      bad++;
      $display("FAIL rdata: got ic=%h dc=%h want %h", ic_rdata, dc_rdata, rd);
    end
    if (drop) begin
      if (e.is_dc) begin dc_read = 1'b0; dc_write = 1'b0; end
      else ic_read = 1'b0;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    total++;
    if ({mem_read, mem_write, ic_ready, dc_ready} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_gap: got rd=%b wr=%b ic_ready=%b dc_ready=%b want all 0",
               mem_read, mem_write, ic_ready, dc_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({mem_read, mem_write, ic_ready, dc_ready, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_state: rd=%b wr=%b ic_ready=%b dc_ready=%b addr=%h wdata=%h want all 0",
               mem_read, mem_write, ic_ready, dc_ready, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_ic_read();
    ic_read = 1'b1;
    ic_addr = 28'h0000010;
    sb.push_back('{1'b0, 1'b0, 28'h0000010, 128'h0});
    @(negedge clk);
    total++;
    if (mem_read !== 1'b1 || mem_addr !== 28'h0000010) begin
      bad++;
      $display("FAIL ic_latency: rd=%b addr=%h want rd=1 addr=0000010", mem_read, mem_addr);
    end
    serve(4, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b1);
  endtask

  task automatic test_dc_write();
    dc_write = 1'b1;
    dc_read  = 1'b1;
    dc_addr  = 28'h00000A4;
    dc_wdata = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    sb.push_back('{1'b1, 1'b1, 28'h00000A4, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF});
    @(negedge clk);
    dc_read = 1'b0;
    dc_wdata = '0;
    serve(3, 128'h0, 1'b1);
    // allocate after write-back from the same master
    dc_read = 1'b1;
    dc_addr = 28'h00000A8;
    sb.push_back('{1'b1, 1'b0, 28'h00000A8, 128'h0});
    serve(1, 128'hCAFE_F00D, 1'b1);
  endtask

  task automatic test_simultaneous();
    ic_read = 1'b1; ic_addr = 28'h0000200;
    dc_read = 1'b1; dc_addr = 28'h0000300;
    sb.push_back('{1'b1, 1'b0, 28'h0000300, 128'h0});
    sb.push_back('{1'b0, 1'b0, 28'h0000200, 128'h0});
    serve(2, 128'h1111, 1'b1);
    serve(2, 128'h2222, 1'b1);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL simul_count: %0d transfers left want 0", sb.size());
    end
  endtask

  task automatic test_continuous();
    do_reset();
    ic_read = 1'b1; ic_addr = 28'h0000400;
    dc_read = 1'b1; dc_addr = 28'h0000500;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (i % 2 == 0) sb.push_back('{1'b1, 1'b0, 28'h0000500, 128'h0});
      else            sb.push_back('{1'b0, 1'b0, 28'h0000400, 128'h0});
`else
      sb.push_back('{1'b1, 1'b0, 28'h0000500, 128'h0});
`endif
    end
    for (int i = 0; i < 4; i++) serve(1, 128'(i + 7), 1'b0);
    ic_read = 1'b0; dc_read = 1'b0;
    repeat (3) @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  task automatic test_addr_stable();
    do_reset();
    ic_read = 1'b1;
    ic_addr = 28'h0000123;
    sb.push_back('{1'b0, 1'b0, 28'h0000123, 128'h0});
    @(negedge clk);
    ic_addr = 28'h0000FFF;
    serve(3, 128'h5A5A, 1'b1);
  endtask

  task automatic test_reset_mid();
    dc_read = 1'b1;
    dc_addr = 28'h0000777;
    @(negedge clk);
    @(negedge clk);
    proc_reset = 1'b1;
    #1;
    total++;
    if ({mem_read, mem_write, dc_ready, ic_ready, mem_addr} !== '0) begin
      bad++;
      $display("FAIL reset_mid: rd=%b wr=%b dc_ready=%b ic_ready=%b addr=%h want all 0",
               mem_read, mem_write, dc_ready, ic_ready, mem_addr);
    end
    dc_read = 1'b0;
    @(negedge clk);
    proc_reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    total++;
    if (dc_ready !== 1'b0 || ic_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_in_idle: dc_ready=%b ic_ready=%b want 0 0", dc_ready, ic_ready);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    total++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_strobe: rd=%b wr=%b want 0 0", mem_read, mem_write);
    end
    ic_read = 1'b1;
    ic_addr = 28'h0000042;
    sb.push_back('{1'b0, 1'b0, 28'h0000042, 128'h0});
    @(negedge clk);
    total++;
    if (mem_read !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_grant: rd=%b want 1", mem_read);
    end
    serve(0, 128'h9, 1'b1);
  endtask

  initial begin
    proc_reset = 1'b1;
    test_reset();
    test_ic_read();
    test_dc_write();
    test_simultaneous();
    test_continuous();
    test_addr_stable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
